dmem_arbiter: RTL

Two-port arbiter and access sequencer for the single-port 64-word data memory. Shares the memory between requester 0 (pipeline MEM stage) and requester 1 (debug/loader port). Latches the winning request, drives the memory for exactly one cycle, and returns registered read data with a valid pulse. Accepts one access per cycle.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_arbiter_if.sv | 32 +++
 rtl/dmem_arb_pick.sv | 20 ++
 rtl/dmem_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: FSM state, port index and latched access request.
package dmem_pkg;

  localparam int DMEM_WORDS = 64;
  localparam int DMEM_DW    = 32;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  typedef logic [0:0] port_t;

  typedef struct packed {
    port_t              port;
    logic               we;
    logic [DMEM_DW-1:0] addr;
    logic [DMEM_DW-1:0] wdata;
  } acc_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side and memory-side signals of the data-memory arbiter; the arbiter is the slave.
interface dmem_arbiter_if #(
  parameter int DW = 32
) ();

  logic          REQ0, REQ1;
  logic          WE0, WE1;
  logic [DW-1:0] ADDR0, ADDR1;
  logic [DW-1:0] WDATA0, WDATA1;
  logic          GNT0, GNT1;
  logic          RVALID0, RVALID1;
  logic [DW-1:0] RDATA0, RDATA1;
  logic          ERR0, ERR1;
  logic [DW-1:0] MEM_ADDRESS;
  logic [DW-1:0] MEM_WRITE_DATA;
  logic          MEM_WRITE;
  logic          MEM_READ;
  logic [DW-1:0] MEM_READ_DATA;

  modport slave (
    input  REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1, MEM_READ_DATA,
    output GNT0, GNT1, RVALID0, RVALID1, RDATA0, RDATA1, ERR0, ERR1,
           MEM_ADDRESS, MEM_WRITE_DATA, MEM_WRITE, MEM_READ
  );

  modport master (
    output REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WDATA0, WDATA1, MEM_READ_DATA,
    input  GNT0, GNT1, RVALID0, RVALID1, RDATA0, RDATA1, ERR0, ERR1,
           MEM_ADDRESS, MEM_WRITE_DATA, MEM_WRITE, MEM_READ
  );

endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational two-way picker: a lone requester wins, on conflict the pointer names the winner.
module dmem_arb_pick
  import dmem_pkg::*;
(
  input  logic [1:0] req_i,
  input  port_t      ptr_i,
  output logic [1:0] gnt_o,
  output port_t      win_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    win_o = '0;
    gnt_o = '0;
    if (&req_i)       win_o = ptr_i;
    else if (req_i[1]) win_o = 1'b1;
    if (|req_i) gnt_o[win_o] = 1'b1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and one-cycle access sequencer for the 64-word data memory.
// Optional round-robin priority is built when DMEM_ARB_RR_EN is defined; otherwise port 0 always wins.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DW     = DMEM_DW,
  parameter int AW_MEM = 6
) (
  input logic            CLK,
  input logic            RST_N,
  dmem_arbiter_if.slave  bus
);

  localparam logic [0:0] S_IDLE   = IDLE;
  localparam logic [0:0] S_ACCESS = ACCESS;

  logic [0:0]    state_q, state_d;
  acc_req_t      lat_q, lat_d;
  logic [1:0]    rvalid_q, rvalid_d;
  logic [1:0]    err_q, err_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic [1:0]    req, gnt_raw, gnt;
  port_t         win, ptr;
  logic          in_access, in_range;

  assign req = {bus.REQ1, bus.REQ0};

`ifdef DMEM_ARB_RR_EN
  port_t ptr_q, ptr_d;

  // After serving a port, the other one has priority on the next conflict.
  assign ptr   = ptr_q;
  assign ptr_d = (|gnt) ? ~win : ptr_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  assign ptr = '0;
`endif

  dmem_arb_pick u_pick (
    .req_i (req),
    .ptr_i (ptr),
    .gnt_o (gnt_raw),
    .win_o (win)
  );

  assign gnt      = RST_N ? gnt_raw : 2'b00;
  assign bus.GNT0 = gnt[0];
  assign bus.GNT1 = gnt[1];

  assign in_access = (state_q == S_ACCESS);
  assign in_range  = (lat_q.addr[DW-1:AW_MEM] == '0);

  // Gating the write strobe with RST_N drops a write caught in its ACCESS cycle by reset.
  assign bus.MEM_WRITE      = in_access & lat_q.we & in_range & RST_N;
  assign bus.MEM_READ       = in_access & ~lat_q.we & in_range;
  assign bus.MEM_ADDRESS    = in_access ? lat_q.addr  : '0;
  assign bus.MEM_WRITE_DATA = in_access ? lat_q.wdata : '0;

  always_comb begin
    state_d  = (|gnt) ? S_ACCESS : S_IDLE;
    lat_d    = lat_q;
    rvalid_d = '0;
    err_d    = '0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (|gnt) begin
      lat_d.port  = win;
      lat_d.we    = win[0] ? bus.WE1    : bus.WE0;
      lat_d.addr  = win[0] ? bus.ADDR1  : bus.ADDR0;
      lat_d.wdata = win[0] ? bus.WDATA1 : bus.WDATA0;
    end
    if (in_access) begin
      rvalid_d[lat_q.port] = 1'b1;
      err_d[lat_q.port]    = ~in_range;
      if (lat_q.port == 1'b0) rdata0_d = in_range ? bus.MEM_READ_DATA : '0;
      else                    rdata1_d = in_range ? bus.MEM_READ_DATA : '0;
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!RST_N) begin
      state_q  <= S_IDLE;
      lat_q    <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign bus.RVALID0 = rvalid_q[0];
  assign bus.RVALID1 = rvalid_q[1];
  assign bus.ERR0    = err_q[0];
  assign bus.ERR1    = err_q[1];
  assign bus.RDATA0  = rdata0_q;
  assign bus.RDATA1  = rdata1_q;

endmodule
